// File: rtl/proc_control_pkg.sv
// Shared encodings for the bus-based processor: opcodes, ALU operation
// selects and the instruction step states.
package proc_pkg;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_SLT = 3'b101;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_SLT = 2'b11;

   typedef enum logic [1:0] {
      T0 = 2'b00,
      T1 = 2'b01,
      T2 = 2'b10,
      T3 = 2'b11
   } step_t;

   // Maps an ALU-class opcode to the operation select the ALU expects.
   function automatic logic [1:0] aluSelect(input logic [2:0] op);
      logic [1:0] sel;
      sel = ALU_ADD;
      case (op)
         OP_SUB:  sel = ALU_SUB;
         OP_AND:  sel = ALU_AND;
         OP_SLT:  sel = ALU_SLT;
         default: sel = ALU_ADD;
      endcase
      return sel;
   endfunction

   function automatic logic isAluOp(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_SLT);
   endfunction

endpackage

// File: rtl/proc_control_if.sv
// Control interface between the sequencing unit (master) and the datapath
// it steers: register file, DIN buffer, A/G latches and the ALU.
interface proc_control_if #(parameter int NREG = 8);

   logic            Run;
   logic [15:0]     DIN;
   logic [NREG-1:0] R_in;
   logic [NREG-1:0] R_out;
   logic            DIN_out;
   logic            A_in;
   logic            G_in;
   logic            G_out;
   logic [1:0]      AddSub_Control;
   logic            Done;

   modport master (
      input  Run, DIN,
      output R_in, R_out, DIN_out, A_in, G_in, G_out, AddSub_Control, Done
   );

   modport slave (
      output Run, DIN,
      input  R_in, R_out, DIN_out, A_in, G_in, G_out, AddSub_Control, Done
   );

endinterface

// File: rtl/proc_control_dec3to8.sv
// 3-bit to 8-bit one-hot decoder with enable; all-zero when disabled.
module dec3to8 (
   input  logic [2:0] w,
   input  logic       en,
   output logic [7:0] y
);

   always_comb begin
      y = '0;
      if (en) y[w] = 1'b1;
   end

endmodule

// File: rtl/proc_control.sv
// Instruction sequencer: captures III XXX YYY from DIN in T0 and walks the
// T1..T3 schedule, decoding datapath controls from the registered state and IR.
module proc_control
   import proc_pkg::*;
#(
   parameter int IR_W = 9,
   parameter int NREG = 8
)(
   input  logic           Clock,
   input  logic           Reset,
   proc_control_if.master bus
);

   step_t           state;
   step_t           stateNext;
   logic [IR_W-1:0] ir;
   logic [2:0]      opcode;
   logic [7:0]      xOneHot;
   logic [7:0]      yOneHot;
   logic [7:0]      rIn;
   logic [7:0]      rOut;
   logic            dinOut;
   logic            aIn;
   logic            gIn;
   logic            gOut;
   logic [1:0]      aluOp;
   logic            done;

   assign opcode = ir[8:6];

   // Decoders are gated off in T0 so no register select can leak while idle.
   dec3to8 xDecoder (.w(ir[5:3]), .en(state != T0), .y(xOneHot));
   dec3to8 yDecoder (.w(ir[2:0]), .en(state != T0), .y(yOneHot));

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= T0;
         ir    <= '0;
      end else begin
         state <= stateNext;
         if (state == T0 && bus.Run) ir <= bus.DIN[IR_W-1:0];
      end
   end

   always_comb begin
      stateNext = state;
      rIn       = '0;
      rOut      = '0;
      dinOut    = 1'b0;
      aIn       = 1'b0;
      gIn       = 1'b0;
      gOut      = 1'b0;
      aluOp     = ALU_ADD;
      done      = 1'b0;
      case (state)
         T0: begin
            if (bus.Run) stateNext = T1;
         end
         T1: begin
            if (isAluOp(opcode)) begin
               rOut      = xOneHot;
               aIn       = 1'b1;
               stateNext = T2;
            end else begin
               // mv, mvi and the reserved opcodes all finish here.
               if (opcode == OP_MV) begin
                  rOut = yOneHot;
                  rIn  = xOneHot;
               end else if (opcode == OP_MVI) begin
                  dinOut = 1'b1;
                  rIn    = xOneHot;
               end
               done      = 1'b1;
               stateNext = T0;
            end
         end
         T2: begin
            rOut      = yOneHot;
            gIn       = 1'b1;
            aluOp     = aluSelect(opcode);
            stateNext = T3;
         end
         T3: begin
            gOut      = 1'b1;
            rIn       = xOneHot;
            done      = 1'b1;
            stateNext = T0;
         end
         default: stateNext = T0;
      endcase
   end

   assign bus.R_in           = NREG'(rIn);
   assign bus.R_out          = NREG'(rOut);
   assign bus.DIN_out        = dinOut;
   assign bus.A_in           = aIn;
   assign bus.G_in           = gIn;
   assign bus.G_out          = gOut;
   assign bus.AddSub_Control = aluOp;
   assign bus.Done           = done;

endmodule

// File: doc/proc_control.md
# proc_control

Instruction-sequencing control unit for the 16-bit bus-based processor. It captures a 9-bit instruction from `DIN`, then steps through a fixed multi-cycle schedule. Each cycle it drives the register-file enables, the bus source selects, the A/G latch enables and the 2-bit operation code to the add/sub/and/slt ALU. It is the producer end of the ALU control interface: the ALU consumes `A` and `Bus`, and this block decides which values are on `Bus` and which operation is selected.

## Interface
- `IR_W`, default 9: instruction width, formatted III XXX YYY (opcode, dest reg X, source reg Y).
- `NREG`, default 8: number of general registers; one-hot select width.
- `Clock`  in  1: single clock; all state changes on its rising edge.
- `Reset`  in  1: synchronous, active-high reset, sampled on the rising edge of `Clock`.
- `Run`  in  1: request to start an instruction; sampled only in state T0.
- `DIN`  in  16: data-in bus; `DIN[8:0]` is the instruction in T0 and the immediate source in mvi.
- `R_in`  out  NREG: one-hot register write enables.
- `R_out`  out  NREG: one-hot register-to-bus drive selects.
- `DIN_out`  out  1: drive `DIN` onto the bus.
- `A_in`  out  1: load the A latch from the bus.
- `G_in`  out  1: load the G latch from the ALU result.
- `G_out`  out  1: drive G onto the bus.
- `AddSub_Control`  out  2: ALU op select. 00 add, 01 sub, 10 and, 11 slt (all-ones if A<Bus unsigned, else zero).
- `Done`  out  1: final cycle of the current instruction.

## Operation
- Opcodes: 000 mv Rx←Ry; 001 mvi Rx←DIN; 010 add; 011 sub; 100 and; 101 slt (each ALU op is Rx←Rx op Ry); 110 and 111 are reserved.
- Internal state: a 9-bit IR register and a 2-bit step counter with states T0, T1, T2, T3.
- T0: if `Run`=1, IR←DIN[8:0] and go to T1; otherwise stay in T0. All outputs are 0.
- T1:
  - mv: `R_out`=onehot(Y), `R_in`=onehot(X), `Done`=1, then T0.
  - mvi: `DIN_out`=1, `R_in`=onehot(X), `Done`=1, then T0.
  - ALU ops: `R_out`=onehot(X), `A_in`=1, then T2.
  - Reserved opcodes: `Done`=1, no enables asserted, then T0.
- T2 (ALU ops only): `R_out`=onehot(Y), `G_in`=1, `AddSub_Control`=opcode-2 mapping (add 00, sub 01, and 10, slt 11), then T3.
- T3: `G_out`=1, `R_in`=onehot(X), `Done`=1, then T0.
- Outputs are decoded combinationally from the registered state and IR. `DIN` never reaches the outputs combinationally.
- Exactly one bus source (`R_out` bit, `DIN_out` or `G_out`) is active in any cycle where the bus is used; none is active in T0.
- `AddSub_Control` is 00 in every cycle except T2.
- X=Y is legal: mv Rx←Rx and add Rx←Rx+Rx proceed normally.

## Timing
- Reset: state←T0 and IR←0 on the edge where `Reset`=1. This applies from any state, including mid-instruction, and the instruction is abandoned. In the following cycle all outputs are 0.
- `Reset` has priority over `Run` in the same cycle.
- Latency from the T0 edge where `Run`=1 is captured to `Done`: mv, mvi and reserved take 1 cycle; ALU ops take 3 cycles.
- `Done` is high for exactly one cycle per instruction.
- `Run` is ignored in T1–T3. If `Run` is held high, the next instruction is captured in the cycle after `Done`, giving no idle gaps beyond T0.
- IR stays stable from capture until the next T0 capture.

## Structure
- Shared package `proc_pkg`: opcode localparams (OP_MV … OP_SLT), ALU control encodings (ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_SLT=2'b11) and state encodings T0–T3. The ALU and this block both import the ALU encodings.
- One sub-module, `dec3to8`: a 3-bit to 8-bit one-hot decoder with an enable. It is instantiated twice, for X and for Y.

## Test plan
- Reset then idle: `Reset`=1 for 1 cycle, `Run`=0 for 5 cycles -> all outputs 0 and no `Done`.
- mvi: `Run`=1, DIN=9'b001_011_000 -> in the next cycle `DIN_out`=1, `R_in`=8'h08, `Done`=1; the cycle after that, all outputs are 0.
- add R2,R5 (DIN=9'b010_010_101) -> T1: `R_out`=8'h04, `A_in`=1; T2: `R_out`=8'h20, `G_in`=1, `AddSub_Control`=00; T3: `G_out`=1, `R_in`=8'h04, `Done`=1.
- slt R1,R0 (DIN=9'b101_001_000) -> T2 shows `AddSub_Control`=11 and `R_out`=8'h01; `Done` follows in T3.
- Back-to-back: `Run` held high with a sub then an mv -> `Done` pulses 3 cycles, then 1 cycle, after capture, with no extra idle cycle. Reserved opcode 111 -> `Done` in T1 with `R_in`=0.
- Reset mid-op: assert `Reset` in T2 of an and instruction -> the next cycle is T0 with all outputs 0, and no `Done` is ever produced for the abandoned instruction.
